intersection_scheduler: RTL and testbench
=========================================

INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 SHALL have parameter GREEN_MIN, default 8: minimum green cycles per phase.
REQ-002 SHALL have parameter GREEN_MAX, default 16: green cycles after which a contested phase ends (GREEN_MAX >= GREEN_MIN >= 1).
REQ-003 SHALL have parameter YELLOW_T, default 3: yellow cycles.
REQ-004 SHALL have parameter ALLRED_T, default 2: all-red clearance cycles.
REQ-005 SHALL have parameter CNT_W, default 5: timer width (2^CNT_W-1 >= GREEN_MAX).
REQ-006 SHALL have port sysclk  in  1  clock, rising edge.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports req_a, req_b  in  1 each  level vehicle demand for direction A/B, sampled each edge.
REQ-009 SHALL have ports pass_a, pass_b  in  1 each  pedestrian request pulse (>=1 cycle) for direction A/B.
REQ-010 SHALL have ports ra, ga, ya, rb, gb, yb  out  1 each  lamp drives for direction A/B.
REQ-011 SHALL have ports pend_a, pend_b  out  1 each  latched pedestrian request pending.
REQ-012 SHALL have port phase  out  3  current state code (REQ-014 order, 0..5).

Function
REQ-013 SHALL be a Moore machine: lamps and phase decoded only from the state register; no combinational input-to-output path.
REQ-014 SHALL have states CLR_A(0), GRN_A(1), YEL_A(2), CLR_B(3), GRN_B(4), YEL_B(5); CLR_x = both red, clearing into green x.
REQ-015 SHALL keep a timer that clears to 0 on every state change, increments each cycle otherwise, and saturates at 2^CNT_W-1.
REQ-016 SHALL hold CLR_x exactly ALLRED_T cycles, then enter GRN_x.
REQ-017 SHALL hold YEL_A exactly YELLOW_T cycles, then enter CLR_B; YEL_B likewise to CLR_A.
REQ-018 SHALL define demand_x = req_x | pend_x.
REQ-019 SHALL leave GRN_x for YEL_x at the edge where demand_other=1 and either (timer >= GREEN_MIN-1 and req_x=0) or timer >= GREEN_MAX-1.
REQ-020 SHALL remain in GRN_x indefinitely while demand_other=0 (rest in green), regardless of timer.
REQ-021 SHALL set pend_x on a sampled pass_x=1 unless state is GRN_x; SHALL clear pend_x on the edge entering GRN_x; clear wins over set on that same edge.
REQ-022 SHALL drive exactly one of r/g/y high per direction at all times; ga and gb SHALL never be high together; ya/yb SHALL only be high in YEL_A/YEL_B.
REQ-023 SHALL, with req and pass changing on the same edge as a transition, use the pre-edge sampled values only.

Reset
REQ-024 SHALL, while rst=1, force state CLR_A, timer 0, pend_a=pend_b=0: ra=rb=1, ga=gb=ya=yb=0, phase=0.
REQ-025 SHALL take effect immediately on rst assertion mid-operation (including mid-green or mid-yellow), with no yellow transition.
REQ-026 SHALL resume at CLR_A on the first sysclk edge after rst deasserts.

Structure
REQ-027 SHALL place the state enum and default timing constants in package intersection_pkg.
REQ-028 SHALL implement the timer as sub-module phase_timer (clear, increment, saturate, CNT_W wide); the FSM and request latches live in the top.

Verification (defaults)
REQ-029 SHALL check: reset pulse, no requests -> ra=rb=1 for 2 cycles, then ga=1 held through cycle 60.
REQ-030 SHALL check: req_b=1 constant, req_a=0 -> GRN_A 8 cycles, YEL_A 3, CLR_B 2, then gb=1 and held.
REQ-031 SHALL check: 1-cycle pass_b at GRN_A timer=3 -> pend_b=1 next cycle, yellow after 8 green cycles, pend_b=0 on the edge gb rises.
REQ-032 SHALL check: req_a=req_b=1 constant -> each green 16 cycles, full cycle period 42, phase sequence 1,2,3,4,5,0 repeating.
REQ-033 SHALL check: rst asserted at GRN_B timer=5 -> same cycle ra=rb=1, pend cleared, phase=0; restart as REQ-029.
REQ-034 SHALL assert every cycle in all tests: one-hot r/g/y per direction and never ga&gb.

Source files
------------

// File: rtl/intersection_pkg.sv
// intersection_pkg: shared types and default timing for the two-way intersection scheduler.
//   state_e       - controller state; the encoding is also the external phase code (0..5)
//   *Def          - default cycle counts and timer width used by intersection_scheduler
package intersection_pkg;

  typedef enum logic [2:0] {
    StClrA = 3'd0,  // both red, clearing into green A
    StGrnA = 3'd1,
    StYelA = 3'd2,
    StClrB = 3'd3,  // both red, clearing into green B
    StGrnB = 3'd4,
    StYelB = 3'd5
  } state_e;

  localparam int unsigned GreenMinDef = 8;
  localparam int unsigned GreenMaxDef = 16;
  localparam int unsigned YellowTDef  = 3;
  localparam int unsigned AllredTDef  = 2;
  localparam int unsigned CntWDef     = 5;

endpackage

// File: rtl/phase_timer.sv
// phase_timer: per-state cycle counter for the intersection scheduler.
//   sysclk - clock, rising edge
//   rst    - asynchronous active-high reset, forces count to 0
//   clear  - synchronous clear (asserted on the edge that changes state)
//   count  - cycles spent in the current state, saturating at 2^CNT_W-1
module phase_timer #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_q != '1) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: Moore traffic-light controller for two conflicting directions A and B.
//   sysclk         - clock, rising edge
//   rst            - asynchronous active-high reset (state CLR_A, timer 0, no pending requests)
//   req_a, req_b   - level vehicle demand per direction
//   pass_a, pass_b - pedestrian request pulses, latched into pend_a/pend_b
//   ra/ya/ga       - direction A lamps; rb/yb/gb - direction B lamps
//   pend_a, pend_b - latched pedestrian requests awaiting their green
//   phase          - current state code (0..5)
module intersection_scheduler
  import intersection_pkg::*;
#(
  parameter int unsigned GREEN_MIN = GreenMinDef,
  parameter int unsigned GREEN_MAX = GreenMaxDef,
  parameter int unsigned YELLOW_T  = YellowTDef,
  parameter int unsigned ALLRED_T  = AllredTDef,
  parameter int unsigned CNT_W     = CntWDef
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       pass_a,
  input  logic       pass_b,
  output logic       ra,
  output logic       ga,
  output logic       ya,
  output logic       rb,
  output logic       gb,
  output logic       yb,
  output logic       pend_a,
  output logic       pend_b,
  output logic [2:0] phase
);

  // Last timer value of each interval: the transition fires on the edge that ends that cycle.
  localparam logic [CNT_W-1:0] GreenMinLast = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GreenMaxLast = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YellowLast   = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AllredLast   = CNT_W'(ALLRED_T - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer;
  logic             pend_a_q, pend_a_d;
  logic             pend_b_q, pend_b_d;
  logic             demand_a, demand_b;
  logic             green_done_a, green_done_b;

  assign demand_a = req_a | pend_a_q;
  assign demand_b = req_b | pend_b_q;

  // A green only yields to a waiting opposite direction; without one it rests indefinitely.
  assign green_done_a = demand_b & (((timer >= GreenMinLast) & ~req_a) | (timer >= GreenMaxLast));
  assign green_done_b = demand_a & (((timer >= GreenMinLast) & ~req_b) | (timer >= GreenMaxLast));

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .sysclk (sysclk),
    .rst    (rst),
    .clear  (state_d != state_q),
    .count  (timer)
  );

  // State register
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q <= StClrA;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClrA: if (timer >= AllredLast) state_d = StGrnA;
      StGrnA: if (green_done_a)        state_d = StYelA;
      StYelA: if (timer >= YellowLast) state_d = StClrB;
      StClrB: if (timer >= AllredLast) state_d = StGrnB;
      StGrnB: if (green_done_b)        state_d = StYelB;
      StYelB: if (timer >= YellowLast) state_d = StClrA;
      default:                         state_d = StClrA;
    endcase
  end

  // Pedestrian latches: entering the matching green clears, and that clear beats a same-edge set.
  always_comb begin
    pend_a_d = pend_a_q;
    if (state_d == StGrnA && state_q != StGrnA) begin
      pend_a_d = 1'b0;
    end else if (pass_a && state_q != StGrnA) begin
      pend_a_d = 1'b1;
    end
  end

  always_comb begin
    pend_b_d = pend_b_q;
    if (state_d == StGrnB && state_q != StGrnB) begin
      pend_b_d = 1'b0;
    end else if (pass_b && state_q != StGrnB) begin
      pend_b_d = 1'b1;
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
    end else begin
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
    end
  end

  // Output decode from the state register only
  always_comb begin
    ra = 1'b1;
    ga = 1'b0;
    ya = 1'b0;
    rb = 1'b1;
    gb = 1'b0;
    yb = 1'b0;
    unique case (state_q)
      StGrnA: begin
        ra = 1'b0;
        ga = 1'b1;
      end
      StYelA: begin
        ra = 1'b0;
        ya = 1'b1;
      end
      StGrnB: begin
        rb = 1'b0;
        gb = 1'b1;
      end
      StYelB: begin
        rb = 1'b0;
        yb = 1'b1;
      end
      default: ;
    endcase
  end

  assign pend_a = pend_a_q;
  assign pend_b = pend_b_q;
  assign phase  = state_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// tb_intersection_scheduler: table-driven check of intersection_scheduler at default timing.
// Each table segment holds inputs for n cycles and the phase/pending values expected in them;
// lamp expectations follow from the phase code.
module tb_intersection_scheduler;

  logic       sysclk = 1'b0;
  logic       rst    = 1'b1;
  logic       req_a  = 1'b0;
  logic       req_b  = 1'b0;
  logic       pass_a = 1'b0;
  logic       pass_b = 1'b0;
  logic       ra, ga, ya, rb, gb, yb;
  logic       pend_a, pend_b;
  logic [2:0] phase;

  always #5 sysclk = ~sysclk;

  intersection_scheduler #(
    .GREEN_MIN (8),
    .GREEN_MAX (16),
    .YELLOW_T  (3),
    .ALLRED_T  (2),
    .CNT_W     (5)
  ) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .req_a  (req_a),
    .req_b  (req_b),
    .pass_a (pass_a),
    .pass_b (pass_b),
    .ra     (ra),
    .ga     (ga),
    .ya     (ya),
    .rb     (rb),
    .gb     (gb),
    .yb     (yb),
    .pend_a (pend_a),
    .pend_b (pend_b),
    .phase  (phase)
  );

  typedef struct {
    logic       rst;
    logic       req_a;
    logic       req_b;
    logic       pass_a;
    logic       pass_b;
    int         n;
    logic [2:0] phase;
    logic       pend_a;
    logic       pend_b;
  } seg_t;

  typedef struct {
    int         row;
    logic [2:0] phase;
    logic [5:0] lamps;  // {ra, ya, ga, rb, yb, gb}
    logic       pend_a;
    logic       pend_b;
  } exp_t;

  seg_t segs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;

  function automatic void seg(logic r, logic qa, logic qb, logic pa, logic pb, int n,
                              logic [2:0] ph, logic ea, logic eb);
    seg_t s;
    s.rst    = r;
    s.req_a  = qa;
    s.req_b  = qb;
    s.pass_a = pa;
    s.pass_b = pb;
    s.n      = n;
    s.phase  = ph;
    s.pend_a = ea;
    s.pend_b = eb;
    segs.push_back(s);
  endfunction

  function automatic logic [5:0] lamps_for(logic [2:0] ph);
    logic [2:0] a, b;
    a = (ph == 3'd1) ? 3'b001 : (ph == 3'd2) ? 3'b010 : 3'b100;
    b = (ph == 3'd4) ? 3'b001 : (ph == 3'd5) ? 3'b010 : 3'b100;
    return {a, b};
  endfunction

  // Lamp invariants on every cycle
  always @(negedge sysclk) begin
    #2;
    if (!done) begin
      checks++;
      if (!$onehot({ra, ya, ga}) || !$onehot({rb, yb, gb}) || (ga && gb)) begin
        failures++;
        $display("FAIL lamp_invariant t=%0t: got a(ryg)=%b%b%b b(ryg)=%b%b%b, want one-hot each, not ga&gb",
                 $time, ra, ya, ga, rb, yb, gb);
      end
    end
  end

  initial begin
    exp_t e, got;
    int   row;
    int   cnt;

    // Reset then idle: two cycles of all-red, then green A rests through cycle 60.
    seg(1, 0, 0, 0, 0, 2, 3'd0, 0, 0);
    seg(0, 0, 0, 0, 0, 2, 3'd0, 0, 0);
    seg(0, 0, 0, 0, 0, 58, 3'd1, 0, 0);

    // Constant demand on B only: A green for minimum, then B rests in green.
    seg(1, 0, 1, 0, 0, 2, 3'd0, 0, 0);
    seg(0, 0, 1, 0, 0, 2, 3'd0, 0, 0);
    seg(0, 0, 1, 0, 0, 8, 3'd1, 0, 0);
    seg(0, 0, 1, 0, 0, 3, 3'd2, 0, 0);
    seg(0, 0, 1, 0, 0, 2, 3'd3, 0, 0);
    seg(0, 0, 1, 0, 0, 20, 3'd4, 0, 0);

    // Pedestrian B at green-A timer 3, pass ignored in own green, pass A cleared on green entry.
    seg(1, 0, 0, 0, 0, 2, 3'd0, 0, 0);
    seg(0, 0, 0, 0, 0, 2, 3'd0, 0, 0);
    seg(0, 0, 0, 0, 0, 3, 3'd1, 0, 0);
    seg(0, 0, 0, 0, 1, 1, 3'd1, 0, 0);
    seg(0, 0, 0, 0, 0, 4, 3'd1, 0, 1);
    seg(0, 0, 0, 0, 0, 3, 3'd2, 0, 1);
    seg(0, 0, 0, 0, 0, 2, 3'd3, 0, 1);
    seg(0, 0, 0, 0, 0, 10, 3'd4, 0, 0);
    seg(0, 0, 0, 0, 1, 1, 3'd4, 0, 0);
    seg(0, 0, 0, 1, 0, 1, 3'd4, 0, 0);
    seg(0, 0, 0, 0, 0, 1, 3'd4, 1, 0);
    seg(0, 0, 0, 0, 0, 3, 3'd5, 1, 0);
    seg(0, 0, 0, 0, 0, 1, 3'd0, 1, 0);
    seg(0, 0, 0, 1, 0, 1, 3'd0, 1, 0);
    seg(0, 0, 0, 0, 0, 5, 3'd1, 0, 0);

    // Contested both ways: 16-cycle greens, 42-cycle period, two full rounds.
    seg(1, 1, 1, 0, 0, 2, 3'd0, 0, 0);
    seg(0, 1, 1, 0, 0, 2, 3'd0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      seg(0, 1, 1, 0, 0, 16, 3'd1, 0, 0);
      seg(0, 1, 1, 0, 0, 3, 3'd2, 0, 0);
      seg(0, 1, 1, 0, 0, 2, 3'd3, 0, 0);
      seg(0, 1, 1, 0, 0, 16, 3'd4, 0, 0);
      seg(0, 1, 1, 0, 0, 3, 3'd5, 0, 0);
      seg(0, 1, 1, 0, 0, 2, 3'd0, 0, 0);
    end

    // Reset mid green B (timer 5) with a pending A request, then normal restart.
    seg(1, 0, 1, 0, 0, 2, 3'd0, 0, 0);
    seg(0, 0, 1, 0, 0, 2, 3'd0, 0, 0);
    seg(0, 0, 1, 0, 0, 8, 3'd1, 0, 0);
    seg(0, 0, 1, 0, 0, 3, 3'd2, 0, 0);
    seg(0, 0, 1, 0, 0, 2, 3'd3, 0, 0);
    seg(0, 0, 1, 0, 0, 2, 3'd4, 0, 0);
    seg(0, 0, 1, 1, 0, 1, 3'd4, 0, 0);
    seg(0, 0, 1, 0, 0, 2, 3'd4, 1, 0);
    seg(1, 0, 1, 0, 0, 2, 3'd0, 0, 0);
    seg(0, 0, 0, 0, 0, 2, 3'd0, 0, 0);
    seg(0, 0, 0, 0, 0, 10, 3'd1, 0, 0);

    row = 0;
    @(posedge sysclk);
    foreach (segs[i]) begin
      for (int k = 0; k < segs[i].n; k++) begin
        @(negedge sysclk);
        rst    = segs[i].rst;
        req_a  = segs[i].req_a;
        req_b  = segs[i].req_b;
        pass_a = segs[i].pass_a;
        pass_b = segs[i].pass_b;
        e.row    = row;
        e.phase  = segs[i].phase;
        e.lamps  = lamps_for(segs[i].phase);
        e.pend_a = segs[i].pend_a;
        e.pend_b = segs[i].pend_b;
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        checks++;
        if ({phase, ra, ya, ga, rb, yb, gb, pend_a, pend_b} !==
            {got.phase, got.lamps, got.pend_a, got.pend_b}) begin
          failures++;
          $display("FAIL row%0d: got phase=%0d lamps=%b pend=%b%b, want phase=%0d lamps=%b pend=%b%b",
                   got.row, phase, {ra, ya, ga, rb, yb, gb}, pend_a, pend_b,
                   got.phase, got.lamps, got.pend_a, got.pend_b);
        end
        row++;
      end
    end

    // Bounded wait for gb under constant B demand: 2 + 8 + 3 + 2 cycles before it rises.
    @(negedge sysclk);
    rst    = 1'b1;
    req_a  = 1'b0;
    req_b  = 1'b0;
    pass_a = 1'b0;
    pass_b = 1'b0;
    @(negedge sysclk);
    @(negedge sysclk);
    rst   = 1'b0;
    req_b = 1'b1;
    cnt   = 0;
    while (cnt < 40) begin
      #1;
      if (gb === 1'b1) break;
      cnt++;
      @(negedge sysclk);
    end
    checks++;
    if (cnt != 15) begin
      failures++;
      $display("FAIL gb_latency: got %0d cycles, want 15", cnt);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge sysclk);
      #1;
      checks++;
      if (gb !== 1'b1 || pend_b !== 1'b0) begin
        failures++;
        $display("FAIL gb_hold cycle %0d: got gb=%b pend_b=%b, want gb=1 pend_b=0", k, gb, pend_b);
      end
    end

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
